// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction sequencer: opcodes, FSM states,
// and the 9-bit instruction decoder.
package isa_pkg;

  localparam logic [3:0] OP_XOR   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SIGN  = 4'b0011;
  localparam logic [3:0] OP_MSB   = 4'b0100;
  localparam logic [3:0] OP_POPC  = 4'b0101;
  localparam logic [3:0] OP_BLT   = 4'b0110;
  localparam logic [3:0] OP_BEQ   = 4'b0111;
  localparam logic [3:0] OP_MOVE  = 4'b1000;
  localparam logic [3:0] OP_SHIFT = 4'b1001;
  localparam logic [3:0] OP_ADDI  = 4'b1010;
  localparam logic [3:0] OP_SUBI  = 4'b1011;
  localparam logic [3:0] OP_JMP0  = 4'b1100;
  localparam logic [3:0] OP_JMP1  = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1110;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  localparam logic [2:0] ACC_REG   = 3'd0;
  localparam logic [8:0] NOP_INSTR = 9'h1E0;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] imm;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] wa;
    logic       we;
  } ctrl_t;

  // ir[3] is reserved and never looked at here
  function automatic ctrl_t decode(input logic [8:0] instr);
    ctrl_t c;
    c.op  = instr[8:5];
    c.imm = 3'd0;
    c.ra  = ACC_REG;
    c.rb  = ACC_REG;
    c.wa  = ACC_REG;
    c.we  = 1'b0;
    case (c.op)
      OP_XOR, OP_ADD, OP_SUB, OP_SIGN, OP_MSB, OP_POPC: begin
        c.rb = instr[2:0];
        c.we = 1'b1;
      end
      OP_MOVE: begin
        if (instr[4]) c.wa = instr[2:0];
        else          c.ra = instr[2:0];
        c.we = 1'b1;
      end
      OP_SHIFT, OP_ADDI, OP_SUBI: begin
        c.imm = instr[2:0];
        c.we  = 1'b1;
      end
      OP_BLT, OP_BEQ: c.rb = instr[2:0];
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/jump_lut.sv
// Jump-target ROM: built-in table from LUT_INIT.
module jump_lut #(
  parameter int PC_W = 10,
  parameter int LUT_DEPTH = 32,
  parameter logic [LUT_DEPTH*PC_W-1:0] LUT_INIT = '0
) (
  input  logic [$clog2(LUT_DEPTH)-1:0] index,
  output logic [PC_W-1:0]              target
);

  logic [PC_W-1:0] rom [LUT_DEPTH];

  always_comb begin
    for (int i = 0; i < LUT_DEPTH; i++) rom[i] = LUT_INIT[i*PC_W +: PC_W];
  end

  assign target = rom[index];

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller driving the ALU and register file from a
// 9-bit instruction memory; one instruction at a time, no pipelining.
module instr_sequencer
  import isa_pkg::*;
#(
  parameter int PC_W = 10,
  parameter int LUT_DEPTH = 32,
  parameter int CNT_W = 16,
  parameter logic [LUT_DEPTH*PC_W-1:0] LUT_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [8:0]       imem_data,
  output logic [3:0]       alu_op,
  output logic [2:0]       alu_imm,
  input  logic             alu_brc_j,
  input  logic             alu_jen,
  output logic [2:0]       rf_ra,
  output logic [2:0]       rf_rb,
  output logic [2:0]       rf_wa,
  output logic             rf_we,
  output logic             done,
  output logic [CNT_W-1:0] instr_count,
  output logic [PC_W-1:0]  pc_out
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [8:0]      ir;
  logic [PC_W-1:0] jump_target;
  ctrl_t           dec;

  jump_lut #(
    .PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH), .LUT_INIT(LUT_INIT)
  ) u_jump_lut (
    .index  (ir[$clog2(LUT_DEPTH)-1:0]),
    .target (jump_target)
  );

  // Decode the fetched word on its way into ir so the EXEC-cycle outputs
  // come straight from flops.
  assign dec       = decode(imem_data);
  assign imem_addr = pc;
  assign pc_out    = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= NOP_INSTR;
      imem_req    <= 1'b0;
      alu_op      <= OP_NOP;
      alu_imm     <= '0;
      rf_ra       <= ACC_REG;
      rf_rb       <= ACC_REG;
      rf_wa       <= ACC_REG;
      rf_we       <= 1'b0;
      done        <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pc          <= '0;
          instr_count <= '0;
          imem_req    <= 1'b1;
          state       <= FETCH;
        end
        FETCH: if (imem_valid) begin
          ir       <= imem_data;
          imem_req <= 1'b0;
          alu_op   <= dec.op;
          alu_imm  <= dec.imm;
          rf_ra    <= dec.ra;
          rf_rb    <= dec.rb;
          rf_wa    <= dec.wa;
          rf_we    <= dec.we;
          state    <= EXEC;
        end
        EXEC: begin
          alu_op  <= OP_NOP;
          alu_imm <= '0;
          rf_ra   <= ACC_REG;
          rf_rb   <= ACC_REG;
          rf_wa   <= ACC_REG;
          rf_we   <= 1'b0;
          if (instr_count != '1) instr_count <= instr_count + 1'b1;
          if (ir[8:5] == OP_HALT) begin
            done  <= 1'b1;
            state <= HALT;
          end else begin
            case (ir[8:5])
              OP_BLT, OP_BEQ: pc <= alu_brc_j ? pc + 1'b1 : jump_target;
              OP_JMP0, OP_JMP1: pc <= alu_jen ? jump_target : pc + 1'b1;
              default: pc <= pc + 1'b1;
            endcase
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        HALT: done <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  // A jump that the ALU refuses to enable means the ALU and sequencer disagree
  a_jump_enabled: assert property (@(posedge clk) disable iff (reset)
    (state == EXEC && (ir[8:5] == OP_JMP0 || ir[8:5] == OP_JMP1)) |-> alu_jen);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: fetch timing, stalls, decode, branches,
// jump wrap, halt and reset during a stalled fetch.
module tb_instr_sequencer;
  localparam int PC_W = 10;
  localparam int LUT_DEPTH = 32;
  localparam int CNT_W = 16;

  function automatic logic [LUT_DEPTH*PC_W-1:0] mk_lut();
    logic [LUT_DEPTH*PC_W-1:0] v;
    v = '0;
    v[3*PC_W +: PC_W] = 10'h040;
    v[5*PC_W +: PC_W] = 10'h3FF;
    return v;
  endfunction
  localparam logic [LUT_DEPTH*PC_W-1:0] LUT = mk_lut();

  logic clk = 0, reset = 1, start = 0, imem_valid = 0, alu_brc_j = 1, alu_jen = 0;
  logic [8:0] imem_data = '0;
  logic imem_req, rf_we, done;
  logic [PC_W-1:0] imem_addr, pc_out;
  logic [3:0] alu_op;
  logic [2:0] alu_imm, rf_ra, rf_rb, rf_wa;
  logic [CNT_W-1:0] instr_count;

  int checks = 0, failures = 0;

  instr_sequencer #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH), .CNT_W(CNT_W), .LUT_INIT(LUT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .alu_op(alu_op), .alu_imm(alu_imm), .alu_brc_j(alu_brc_j), .alu_jen(alu_jen),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa), .rf_we(rf_we),
    .done(done), .instr_count(instr_count), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one fetch after `stalls` idle cycles; returns with the DUT in EXEC.
  task automatic fetch(input logic [8:0] word, input int stalls, input logic [PC_W-1:0] addr);
    for (int i = 0; i < stalls; i++) begin
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, addr);
      chk("stall_we", rf_we, 0);
      chk("stall_op", alu_op, 4'hF);
      tick();
    end
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, addr);
    imem_valid = 1;
    imem_data  = word;
    tick();
    imem_valid = 0;
    imem_data  = '0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_req", imem_req, 0);
    chk("rst_op", alu_op, 4'hF);
    chk("rst_we", rf_we, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_pc", pc_out, 0);
    reset = 0;
    tick();
    chk("idle_req", imem_req, 0);

    start = 1; tick(); start = 0;
    fetch(9'h020, 0, 10'h000);             // add r0,r0
    chk("add_op", alu_op, 4'h1);
    chk("add_we", rf_we, 1);
    chk("add_rb", rf_rb, 0);
    tick();
    chk("add_pc", pc_out, 1);
    chk("add_cnt", instr_count, 1);
    chk("add_we_off", rf_we, 0);

    fetch(9'h145, 3, 10'h001);             // addi 5 after 3-cycle stall
    chk("addi_op", alu_op, 4'hA);
    chk("addi_imm", alu_imm, 5);
    chk("addi_we", rf_we, 1);
    tick();
    chk("addi_pc", pc_out, 2);
    chk("addi_imm_off", alu_imm, 0);

    fetch(9'h113, 0, 10'h002);             // move acc -> r3
    chk("movw_op", alu_op, 4'h8);
    chk("movw_wa", rf_wa, 3);
    chk("movw_ra", rf_ra, 0);
    chk("movw_we", rf_we, 1);
    tick();
    fetch(9'h106, 1, 10'h003);             // move r6 -> acc
    chk("movr_ra", rf_ra, 6);
    chk("movr_wa", rf_wa, 0);
    tick();
    chk("movr_pc", pc_out, 4);

    fetch(9'h0E3, 0, 10'h004);             // beq taken
    chk("beq_op", alu_op, 4'h7);
    chk("beq_rb", rf_rb, 3);
    chk("beq_we", rf_we, 0);
    alu_brc_j = 0;
    tick();
    alu_brc_j = 1;
    chk("beq_taken_pc", pc_out, 10'h040);
    fetch(9'h0E3, 0, 10'h040);             // beq not taken
    tick();
    chk("beq_fall_pc", pc_out, 10'h041);

    fetch(9'h185, 0, 10'h041);             // jump to lut[5]
    chk("jmp_we", rf_we, 0);
    alu_jen = 1;
    tick();
    alu_jen = 0;
    chk("jmp_pc", pc_out, 10'h3FF);
    fetch(9'h1E0, 0, 10'h3FF);             // nop at top of memory
    chk("nop_op", alu_op, 4'hF);
    chk("nop_we", rf_we, 0);
    tick();
    chk("wrap_pc", pc_out, 10'h000);
    chk("cnt8", instr_count, 8);

    fetch(9'h1C0, 0, 10'h000);             // halt
    chk("halt_done_exec", done, 0);
    tick();
    chk("halt_done", done, 1);
    chk("halt_pc", pc_out, 0);
    chk("halt_cnt", instr_count, 9);
    chk("halt_req", imem_req, 0);
    start = 1; tick(); start = 0;
    tick();
    chk("halt_hold", done, 1);
    chk("halt_cnt_frozen", instr_count, 9);
    chk("halt_req_hold", imem_req, 0);

    reset = 1; tick(); reset = 0;
    chk("rerst_done", done, 0);
    start = 1; tick(); start = 0;
    fetch(9'h020, 0, 10'h000);
    tick();
    chk("pre_stall_pc", pc_out, 1);
    tick(); tick();                        // stalled fetch at pc 1
    chk("stall2_req", imem_req, 1);
    reset = 1; tick(); reset = 0;
    chk("midrst_req", imem_req, 0);
    chk("midrst_pc", pc_out, 0);
    chk("midrst_cnt", instr_count, 0);
    imem_valid = 1; imem_data = 9'h020;
    tick(); tick();
    imem_valid = 0;
    chk("late_valid_op", alu_op, 4'hF);
    chk("late_valid_we", rf_we, 0);
    chk("late_valid_req", imem_req, 0);
    chk("late_valid_pc", pc_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end
endmodule
